// File: rtl/pipeline_stage_buffer_pkg.sv
// Shared definitions for the pipeline stage buffer: occupancy states and
// the layout of the control payload (EX | MEM | WB fields).
package pipeline_stage_buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int unsigned EX_W    = 21;
  localparam int unsigned MEM_W   = 7;
  localparam int unsigned WB_W    = 4;
  localparam int unsigned EX_OFF  = 0;
  localparam int unsigned MEM_OFF = EX_OFF + EX_W;
  localparam int unsigned WB_OFF  = MEM_OFF + MEM_W;
  localparam int unsigned CTRL_W_DEF = EX_W + MEM_W + WB_W;

  // Number of held entries for a given occupancy state.
  function automatic logic [1:0] count_of(state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stage_buffer_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream side
// (in_*) and downstream side (out_*). The stage uses the slave view;
// the surrounding logic (source and sink) uses the master view.
interface pipeline_stage_buffer_if
  import pipeline_stage_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 288,
  parameter int unsigned CTRL_W = CTRL_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipeline_stage_buffer.sv
// Pipeline stage buffer: holds up to two entries (head + skid) with a
// registered in_ready when SKID=1, or a single entry with combinational
// ready when SKID=0. Flush discards everything, including the entry
// offered in the flush cycle.
module pipeline_stage_buffer
  import pipeline_stage_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 288,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter bit          SKID   = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     Flush,
  pipeline_stage_buffer_if.slave   bus,
  output logic [1:0]               count
);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready;
  logic              push;
  logic              pop;

  // Handshake qualifiers. Flush forces ready so upstream never stalls on
  // a redirect; the offered entry is then swallowed by the flush.
  always_comb begin
    if (SKID) begin
      in_ready = in_ready_q | Flush;
    end else begin
      in_ready = !out_valid_q | bus.out_ready | Flush;
    end
    push = bus.in_valid & in_ready;
    pop  = out_valid_q & bus.out_ready;
  end

  // Next-state and payload movement. With SKID=0 a push in ONE always
  // coincides with a pop, so the same state machine never reaches TWO.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_data_d = bus.in_data;
            head_ctrl_d = bus.in_ctrl;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_data_d = bus.in_data;
            head_ctrl_d = bus.in_ctrl;
          end else if (push) begin
            skid_data_d = bus.in_data;
            skid_ctrl_d = bus.in_ctrl;
            state_d     = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Output drive; control collapses to an all-zero bubble when empty.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid_q;
    bus.out_data  = head_data_q;
    bus.out_ctrl  = out_valid_q ? head_ctrl_q : '0;
    count         = count_of(state_q);
  end

endmodule
